// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the 32-bit instruction memory. A byte stream arrives over a
// valid/ready handshake: a 16-bit big-endian word count N (1..DEPTH), then
// 4*N payload bytes. Each group of four bytes is assembled big-endian and
// written to consecutive word-aligned byte addresses starting at 0. The CPU
// is held in stall for as long as the loader is not idle.
//
// Optional feature (define IMEM_LOADER_CHECKSUM_EN):
//   One extra byte follows the payload. It must equal the XOR of all payload
//   bytes. A match completes the load and a mismatch flags an error. Words
//   that were already written are left in memory either way.
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   reset     in   asynchronous active-high reset
//   start     in   one-cycle pulse, begins a load when idle (ignored otherwise)
//   rx_data   in   [7:0] incoming byte
//   rx_valid  in   rx_data is valid
//   rx_ready  out  loader accepts a byte this cycle (combinational from state)
//   wr_en     out  one-cycle memory write strobe
//   wr_addr   out  [AW-1:0] byte address of the write, bits [1:0] always 0
//   wr_data   out  [31:0] word to write
//   cpu_hold  out  CPU must stall (loader not idle)
//   busy      out  copy of cpu_hold for status/LED use
//   done      out  one-cycle pulse on successful completion
//   error     out  sticky error flag, cleared by the next accepted start
//   word_cnt  out  [10:0] words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [10:0]   word_cnt
);

  // S_FLUSH is the single cycle in which the last word's write strobe is on
  // the bus. No byte is accepted there, so any trailing byte on the link
  // waits for the checksum state or is left for the next load.
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_H, S_HDR_L, S_PAYLOAD, S_FLUSH, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_H, S_HDR_L, S_PAYLOAD, S_FLUSH, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [15:0] DEPTH_N = 16'(DEPTH);

  state_t       state;
  state_t       next_state;

  logic [15:0]  n_words;    // header word count
  logic [1:0]   byte_idx;   // position of the next payload byte in its word
  logic [23:0]  word_sr;    // first three bytes of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]   csum_acc;   // running XOR of payload bytes
`endif

  logic [15:0]  hdr_n;
  logic         hdr_bad;
  logic         word_done;
  logic         last_word;

  // The full count is formed in the cycle the low header byte arrives, so the
  // range decision is made before that byte is even registered.
  assign hdr_n   = {n_words[15:8], rx_data};
  assign hdr_bad = (hdr_n == 16'd0) || (hdr_n > DEPTH_N);

  // rx_ready is constant 1 in PAYLOAD, so rx_valid alone qualifies a byte
  // there. This also keeps rx_ready out of its own fan-in.
  assign word_done = (state == S_PAYLOAD) && rx_valid && (byte_idx == 2'd3);
  assign last_word = (({5'd0, word_cnt} + 16'd1) == n_words);

  assign cpu_hold = (state != S_IDLE);
  assign busy     = cpu_hold;
  assign done     = (state == S_DONE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_HDR_H;
      end
      S_HDR_H: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = S_HDR_L;
      end
      S_HDR_L: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = hdr_bad ? S_ERR : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        rx_ready = 1'b1;
        if (word_done && last_word) next_state = S_FLUSH;
      end
      S_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        next_state = S_CSUM;
`else
        next_state = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = (rx_data == csum_acc) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath. There is no storage array here, only control registers, and
  // all of them take a defined value on reset so an aborted load leaves the
  // outputs clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      word_cnt <= '0;
      error    <= 1'b0;
      n_words  <= '0;
      byte_idx <= '0;
      word_sr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_acc <= '0;
`endif
    end else begin
      wr_en <= 1'b0;

      // Step to the next word address once the strobe has been presented.
      // After the final word the address is left where it was, so a load of
      // DEPTH words never wraps the address back to 0.
      if (wr_en && ({5'd0, word_cnt} != n_words)) begin
        wr_addr <= wr_addr + AW'(4);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            error    <= 1'b0;
            word_cnt <= '0;
            wr_addr  <= '0;
            byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc <= '0;
`endif
          end
        end
        S_HDR_H: begin
          if (rx_valid) n_words[15:8] <= rx_data;
        end
        S_HDR_L: begin
          if (rx_valid) n_words[7:0] <= rx_data;
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            word_sr  <= {word_sr[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc <= csum_acc ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {word_sr, rx_data};
              word_cnt <= word_cnt + 11'd1;
            end
          end
        end
        default: ;
      endcase

      // Raised on entry to S_ERR and held until the next accepted start.
      if (next_state == S_ERR) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Stimulus tasks compute the expected
// write sequence (address, word, count) and done timing straight from the
// stream format and push them onto queues; a monitor on the falling clock
// edge pops and compares whenever the DUT strobes wr_en or done.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [10:0]   word_cnt;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [10:0]   cnt;
  } exp_wr_t;

  exp_wr_t       exp_q[$];
  int            exp_done_q[$];
  logic [7:0]    pay[$];

  int            n_checks    = 0;
  int            n_err       = 0;
  int            cyc         = 0;
  int            wr_seen     = 0;
  int            done_seen   = 0;
  int            last_hs_cyc = 0;
  logic          prev_wr     = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  exp_wr_t       mon_e;
  int            mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every write strobe and done pulse with the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wr_seen++;
        last_wr_addr = wr_addr;
        check("wr_en_spacing", 32'(prev_wr), 32'd0);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr",  32'(wr_addr),  32'(mon_e.addr));
          check("wr_data",  wr_data,       mon_e.data);
          check("word_cnt", 32'(word_cnt), 32'(mon_e.cnt));
        end else begin
          check("wr_en_unexpected", 32'(wr_en), 32'd0);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done_q.size() > 0) begin
          mon_d = exp_done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_d));
        end else begin
          check("done_unexpected", 32'(done), 32'd0);
        end
      end
      prev_wr = wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time (errors=%0d)", n_err);
    $fatal(1, "watchdog expired");
  end

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  // 'waits' counts cycles the byte was offered but not taken.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    logic hs;
    int   hs_cyc;
    waits    = 0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      hs     = rx_ready;
      hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) break;
      waits++;
    end
    if (waits >= 64) check("byte_accept_timeout", 32'(waits), 32'd0);
    rx_valid    = 1'b0;
    last_hs_cyc = hs_cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait until all expected events have been seen and the loader is idle.
  task automatic wait_quiet();
    int t;
    for (t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && exp_done_q.size() == 0 && !cpu_hold) break;
    end
    if (t >= 64) check("quiet_timeout", 32'(exp_q.size() + exp_done_q.size()), 32'd0);
    check("cpu_hold_idle", 32'(cpu_hold), 32'd0);
    check("busy_idle",     32'(busy),     32'd0);
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // Reference model: word w is payload bytes 4w..4w+3 big-endian at byte
  // address 4w, and the count reads w+1 while it is being written.
  task automatic run_load(input int n, input int gap_mode, input bit mid_start,
                          input bit csum_bad, output int stalls);
    int w;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
`endif
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      exp_wr_t e;
      e.addr = AW'(4 * i);
      e.data = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
      e.cnt  = 11'(i + 1);
      exp_q.push_back(e);
    end
    pulse_start();
    check("error_cleared_on_start", 32'(error), 32'd0);
    send_byte(8'(n >> 8), 0, w);
    send_byte(8'(n & 255), 0, w);
    for (int i = 0; i < 4 * n; i++) begin
      if (mid_start && i == 5) start = 1'b1;
      send_byte(pay[i], gap_for(gap_mode), w);
      start  = 1'b0;
      stalls += w;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs ^= pay[i];
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_bad ? (cs ^ 8'h01) : cs, 0, w);
    if (!csum_bad) exp_done_q.push_back(last_hs_cyc + 1);
`else
    if (!csum_bad) exp_done_q.push_back(last_hs_cyc + 2);
`endif
    wait_quiet();
  endtask

  task automatic run_bad_header(input logic [7:0] hi, input logic [7:0] lo);
    int w;
    int wr0;
    wr0 = wr_seen;
    pulse_start();
    check("error_cleared_on_start", 32'(error), 32'd0);
    send_byte(hi, 0, w);
    send_byte(lo, 0, w);
    wait_quiet();
    check("bad_hdr_error",    32'(error),         32'd1);
    check("bad_hdr_word_cnt", 32'(word_cnt),      32'd0);
    check("bad_hdr_no_write", 32'(wr_seen - wr0), 32'd0);
  endtask

  task automatic fill_random(input int nbytes);
    pay.delete();
    for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    int stalls;
    int w;
    int d0;
    int wr0;
    int rdy_cnt;
    logic [7:0] directed [8];

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_wr_addr",  32'(wr_addr),  32'd0);
    check("rst_wr_data",  wr_data,       32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed two-word load.
    directed = '{8'h23, 8'h64, 8'h65, 8'h66, 8'h69, 8'h6E, 8'h65, 8'h20};
    pay.delete();
    foreach (directed[i]) pay.push_back(directed[i]);
    d0 = done_seen;
    run_load(2, 0, 1'b0, 1'b0, stalls);
    check("dir_word_cnt",   32'(word_cnt),         32'd2);
    check("dir_error",      32'(error),            32'd0);
    check("dir_done_count", 32'(done_seen - d0),   32'd1);

    // Header out of range: zero words, then DEPTH+1 words.
    run_bad_header(8'h00, 8'h00);
    run_bad_header(8'h04, 8'h01);

    // Maximum-size load with continuous valid.
    fill_random(4 * DEPTH);
    d0 = done_seen;
    run_load(DEPTH, 0, 1'b0, 1'b0, stalls);
    check("full_payload_stalls", 32'(stalls),         32'd0);
    check("full_last_addr",      32'(last_wr_addr),   32'hFFC);
    check("full_word_cnt",       32'(word_cnt),       32'(DEPTH));
    check("full_done_count",     32'(done_seen - d0), 32'd1);

    // Reset after six payload bytes of a three-word load.
    fill_random(12);
    begin
      exp_wr_t e;
      e.addr = '0;
      e.data = {pay[0], pay[1], pay[2], pay[3]};
      e.cnt  = 11'd1;
      exp_q.push_back(e);
    end
    wr0 = wr_seen;
    d0  = done_seen;
    pulse_start();
    send_byte(8'h00, 0, w);
    send_byte(8'h03, 0, w);
    for (int i = 0; i < 6; i++) send_byte(pay[i], 0, w);
    reset = 1'b1;
    #1;
    check("abort_wr_count", 32'(wr_seen - wr0), 32'd1);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    check("abort_wr_en",    32'(wr_en),    32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_word_cnt", 32'(word_cnt), 32'd0);
    check("abort_wr_addr",  32'(wr_addr),  32'd0);
    check("abort_wr_data",  wr_data,       32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    rdy_cnt = 0;
    for (int i = 6; i < 12; i++) begin
      rx_data  = pay[i];
      rx_valid = 1'b1;
      @(negedge clk);
      if (rx_ready) rdy_cnt++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_ignored_ready", 32'(rdy_cnt),         32'd0);
    check("abort_no_more_wr",    32'(wr_seen - wr0),   32'd1);
    check("abort_no_done",       32'(done_seen - d0),  32'd0);
    check("abort_idle",          32'(cpu_hold),        32'd0);

    // Valid toggling every cycle with a start pulse mid-payload.
    fill_random(12);
    d0 = done_seen;
    run_load(3, 1, 1'b1, 1'b0, stalls);
    check("toggle_word_cnt",   32'(word_cnt),       32'd3);
    check("toggle_done_count", 32'(done_seen - d0), 32'd1);

    // Random sizes and random gaps.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 6));
      fill_random(4 * n);
      d0 = done_seen;
      run_load(n, 2, k[0], 1'b0, stalls);
      check("rand_word_cnt",   32'(word_cnt),       32'(n));
      check("rand_done_count", 32'(done_seen - d0), 32'd1);
      check("rand_error",      32'(error),          32'd0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum of 30 29 0A 23 is 0x30; then the same payload with 0x31.
    pay.delete();
    pay.push_back(8'h30); pay.push_back(8'h29); pay.push_back(8'h0A); pay.push_back(8'h23);
    d0 = done_seen;
    run_load(1, 0, 1'b0, 1'b0, stalls);
    check("csum_ok_done",  32'(done_seen - d0), 32'd1);
    check("csum_ok_error", 32'(error),          32'd0);
    d0  = done_seen;
    wr0 = wr_seen;
    run_load(1, 0, 1'b0, 1'b1, stalls);
    check("csum_bad_error",   32'(error),          32'd1);
    check("csum_bad_no_done", 32'(done_seen - d0), 32'd0);
    check("csum_bad_written", 32'(wr_seen - wr0),  32'd1);
`endif

    check("scoreboard_drained", 32'(exp_q.size() + exp_done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
